// File: rtl/vram_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vram_pkg
// Brief    : Shared constants, tag/phase encodings and the raster phase decode
//            used by the video-RAM arbiter and its tag pipeline.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
package vram_pkg;

   // Owner tag carried alongside each RAM access
   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_SPR  = 2'd1;
   localparam logic [1:0] TAG_UI   = 2'd2;
   localparam logic [1:0] TAG_CPU  = 2'd3;

   // Raster phase
   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_HBLANK = 2'd1,
      PH_VBLANK = 2'd2
   } phase_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;

   // Vertical blank dominates horizontal blank
   function automatic phase_t decode_phase(input logic [9:0] x,
                                           input logic [8:0] y,
                                           input logic [9:0] h_lim,
                                           input logic [8:0] v_lim);
      if (y >= v_lim) return PH_VBLANK;
      if (x >= h_lim) return PH_HBLANK;
      return PH_ACTIVE;
   endfunction

endpackage
`default_nettype wire

// File: rtl/vram_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vram_arbiter_if
// Brief    : Requester, raster and RAM-port signals of the video-RAM arbiter.
//            slave = arbiter side, master = requesters/RAM side.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface vram_arbiter_if;
   logic [9:0]  CounterX;
   logic [8:0]  CounterY;
   logic        spr_req;
   logic [15:0] spr_addr;
   logic        spr_gnt;
   logic        spr_vld;
   logic        ui_req;
   logic [15:0] ui_addr;
   logic        ui_gnt;
   logic        ui_vld;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic        cpu_gnt;
   logic        cpu_vld;
   logic [15:0] addr;
   logic        ram_we;
   logic [31:0] ram_wdata;
   logic [31:0] fromRAM;

   modport slave (
      input  CounterX, CounterY,
      input  spr_req, spr_addr, ui_req, ui_addr,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, fromRAM,
      output spr_gnt, spr_vld, ui_gnt, ui_vld, cpu_gnt, cpu_vld,
      output addr, ram_we, ram_wdata
   );

   modport master (
      output CounterX, CounterY,
      output spr_req, spr_addr, ui_req, ui_addr,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, fromRAM,
      input  spr_gnt, spr_vld, ui_gnt, ui_vld, cpu_gnt, cpu_vld,
      input  addr, ram_we, ram_wdata
   );
endinterface
`default_nettype wire

// File: rtl/vram_tagpipe.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vram_tagpipe
// Brief    : Delays the owner tag of each issued access by the RAM read
//            latency and decodes it into per-requester valid strobes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module vram_tagpipe
   import vram_pkg::*;
#(
   parameter int RD_LAT = 1
)(
   input  wire logic       clk,
   input  wire logic       rst,      // asynchronous, active-low
   input  wire logic [1:0] tag_in,   // tag registered together with addr
   output logic            spr_vld,
   output logic            ui_vld,
   output logic            cpu_vld
);

   logic [1:0] r_pipe [RD_LAT];

   // Shift the owner tag one stage per cycle; reset flushes in-flight reads
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= TAG_NONE;
      end else begin
         for (int i = RD_LAT - 1; i > 0; i--) r_pipe[i] <= r_pipe[i-1];
         r_pipe[0] <= tag_in;
      end
   end

   assign spr_vld = (r_pipe[RD_LAT-1] == TAG_SPR);
   assign ui_vld  = (r_pipe[RD_LAT-1] == TAG_UI);
   assign cpu_vld = (r_pipe[RD_LAT-1] == TAG_CPU);

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : vram_arbiter
// Brief    : Shares one video-RAM port between sprite, UI and CPU requesters
//            with raster-phase dependent priority and a CPU starvation guard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int RD_LAT     = 1,
   parameter int STARVE_MAX = 15
)(
   input  wire logic      clk,
   input  wire logic      rst,       // asynchronous, active-low
   vram_arbiter_if.slave  bus
);

   localparam logic [9:0] H_LIM      = 10'(H_ACTIVE);
   localparam logic [8:0] V_LIM      = 9'(V_ACTIVE);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   phase_t     w_phase;
   logic       w_force_cpu;
   logic [1:0] w_win;
   logic [3:0] r_starve;
   logic [1:0] r_tag;

   assign w_phase     = decode_phase(bus.CounterX, bus.CounterY, H_LIM, V_LIM);
   assign w_force_cpu = bus.cpu_req && (r_starve == STARVE_LIM);

   // Pick this cycle's winner; a saturated starvation count overrides the phase
   always_comb begin
      w_win = TAG_NONE;
      if (w_force_cpu) begin
         w_win = TAG_CPU;
      end else begin
         case (w_phase)
            PH_ACTIVE: begin
               if      (bus.ui_req)  w_win = TAG_UI;
               else if (bus.spr_req) w_win = TAG_SPR;
               else if (bus.cpu_req) w_win = TAG_CPU;
            end
            PH_HBLANK: begin
               if      (bus.spr_req) w_win = TAG_SPR;
               else if (bus.ui_req)  w_win = TAG_UI;
               else if (bus.cpu_req) w_win = TAG_CPU;
            end
            default: begin
               if      (bus.cpu_req) w_win = TAG_CPU;
               else if (bus.spr_req) w_win = TAG_SPR;
               else if (bus.ui_req)  w_win = TAG_UI;
            end
         endcase
      end
   end

   // Register grant pulses and the winner's RAM command; idle cycles hold addr
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.spr_gnt   <= 1'b0;
         bus.ui_gnt    <= 1'b0;
         bus.cpu_gnt   <= 1'b0;
         bus.addr      <= 16'h0000;
         bus.ram_we    <= 1'b0;
         bus.ram_wdata <= 32'h0000_0000;
         r_tag         <= TAG_NONE;
      end else begin
         bus.spr_gnt <= (w_win == TAG_SPR);
         bus.ui_gnt  <= (w_win == TAG_UI);
         bus.cpu_gnt <= (w_win == TAG_CPU);
         bus.ram_we  <= (w_win == TAG_CPU) && bus.cpu_we;
         // CPU writes return no data, so they carry no owner tag
         r_tag       <= ((w_win == TAG_CPU) && bus.cpu_we) ? TAG_NONE : w_win;
         case (w_win)
            TAG_SPR: bus.addr <= bus.spr_addr;
            TAG_UI:  bus.addr <= bus.ui_addr;
            TAG_CPU: begin
               bus.addr      <= bus.cpu_addr;
               bus.ram_wdata <= bus.cpu_wdata;
            end
            default: ;
         endcase
      end
   end

   // Count cycles the CPU waits; saturate at the limit, clear on CPU grant
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve <= 4'd0;
      end else if (w_win == TAG_CPU) begin
         r_starve <= 4'd0;
      end else if (bus.cpu_req && (r_starve != STARVE_LIM)) begin
         r_starve <= r_starve + 4'd1;
      end
   end

   vram_tagpipe #(
      .RD_LAT (RD_LAT)
   ) u_tagpipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (r_tag),
      .spr_vld (bus.spr_vld),
      .ui_vld  (bus.ui_vld),
      .cpu_vld (bus.cpu_vld)
   );

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
# vram_arbiter

- Shares the single video-RAM read/write port between three requesters:
  - the sprite line manager (sprite attribute and pattern fetches);
  - the UI tile converter (UI layer fetches);
  - the CPU bus (reads and writes).
- Priority depends on the raster position (active display, horizontal blank, vertical blank).
- A starvation guard ensures CPU accesses always complete.
- Sits between the requesters and the RAM macro; read data is broadcast on `fromRAM` and tagged per requester by a one-cycle valid strobe.

## Interface
Parameters:
- `H_ACTIVE`, 640, first CounterX value of horizontal blank
- `V_ACTIVE`, 480, first CounterY value of vertical blank
- `RD_LAT`, 1, RAM read latency in cycles from registered `addr` to valid `fromRAM` (1..3)
- `STARVE_MAX`, 15, CPU wait cycles before forced grant (1..15)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, shared with RAM
- `rst`  in  1  asynchronous active-low reset
- `CounterX`  in  10  raster column
- `CounterY`  in  9  raster line
- `spr_req`  in  1  sprite read request
- `spr_addr`  in  16  sprite read address
- `spr_gnt`  out  1  sprite request accepted
- `spr_vld`  out  1  `fromRAM` holds sprite data
- `ui_req`  in  1  UI read request
- `ui_addr`  in  16  UI read address
- `ui_gnt`  out  1  UI request accepted
- `ui_vld`  out  1  `fromRAM` holds UI data
- `cpu_req`  in  1  CPU request
- `cpu_we`  in  1  CPU write when 1
- `cpu_addr`  in  16  CPU address
- `cpu_wdata`  in  32  CPU write data
- `cpu_gnt`  out  1  CPU request accepted
- `cpu_vld`  out  1  `fromRAM` holds CPU read data (not asserted for writes)
- `addr`  out  16  registered RAM address
- `ram_we`  out  1  registered RAM write enable
- `ram_wdata`  out  32  registered RAM write data
- `fromRAM`  in  32  RAM read data

## Operation
- **Phase, decoded combinationally each cycle:**
  - VBLANK if CounterY >= V_ACTIVE;
  - otherwise HBLANK if CounterX >= H_ACTIVE;
  - otherwise ACTIVE.
- **Priority order by phase:**
  - ACTIVE: ui > spr > cpu.
  - HBLANK: spr > ui > cpu.
  - VBLANK: cpu > spr > ui.
- **Starvation counter (4 bits):**
  - Increments each cycle `cpu_req`=1 and `cpu_gnt` is not issued.
  - Saturates at STARVE_MAX.
  - Clears on a CPU grant.
  - At STARVE_MAX, the CPU wins the next arbitration regardless of phase.
- **Arbitration:**
  - One request is accepted per cycle; no idle cycles between back-to-back grants.
  - The winner's `gnt` pulses for exactly one cycle.
  - On the same edge, `addr`/`ram_we`/`ram_wdata` are loaded from the winner.
  - With no request: `addr` holds, `ram_we`=0.
- **Request/grant handshake:**
  - A requester holds req/addr stable until its gnt is sampled high.
  - req still high on the cycle after gnt counts as a new request.
- **Read data tagging:**
  - The owner tag (2 bits: none/spr/ui/cpu) travels through an RD_LAT-deep tag pipeline.
  - The matching `*_vld` pulses when `fromRAM` is valid.
  - CPU writes enter tag "none".
- **Illegal input:** `cpu_we`=1 only meaningful with `cpu_req`; other requesters are read-only.

## Timing
- **Reset:**
  - Async assert clears `addr`=0, `ram_we`=0, `ram_wdata`=0, all `gnt`=0, all `vld`=0, starvation counter=0, tag pipeline=none.
  - In-flight reads are discarded; no `vld` after reset.
  - Deassertion is synchronous to `clk`.
- **Grant timing:** request sampled at edge N → `gnt` high and `addr` valid during cycle N..N+1.
- **Read latency:**
  - `*_vld` high during cycle N+RD_LAT..N+RD_LAT+1, aligned with `fromRAM`.
  - Total request-to-data is RD_LAT+1 edges.
- **Phase boundaries:**
  - Phase is evaluated on the same edge as the arbitration.
  - A request pending across an ACTIVE→HBLANK edge is re-ranked on that edge.
- **Simultaneous events:**
  - Starvation saturation beats phase priority.
  - With all three requesting under constant input, the CPU is guaranteed a grant within STARVE_MAX+1 cycles.
- **Throughput:** 1 access per cycle sustained.

## Structure
- Shared package `vram_pkg` holds:
  - tag encoding constants TAG_NONE=0, TAG_SPR=1, TAG_UI=2, TAG_CPU=3;
  - phase encoding PH_ACTIVE, PH_HBLANK, PH_VBLANK;
  - default H_ACTIVE/V_ACTIVE.
- One sub-module `vram_tagpipe`: RD_LAT-deep tag shift register plus tag→one-hot vld decode.
- Priority selection and starvation counter stay in the top module.

## Test plan
- **Reset mid-read:** RD_LAT=2, ui read at addr 0x0100, reset asserted 1 cycle later → no `ui_vld` ever; all outputs 0.
- **ACTIVE contention:** CounterX=100, CounterY=10, spr/ui/cpu requesting together → order ui, spr, cpu; `addr` sequence matches each requester's address.
- **HBLANK contention:** CounterX=700, spr/ui both requesting continuously → spr granted every cycle; `fromRAM`=0xDEADBEEF returned with `spr_vld` exactly RD_LAT+1 edges after the request edge.
- **Starvation:**
  - Setup: CounterX=100, spr and ui requesting continuously, `cpu_req` held high, STARVE_MAX=15.
  - Expected: `cpu_gnt` on the 16th cycle; counter returns to 0.
- **VBLANK CPU write:** CounterY=490, `cpu_we`=1, `cpu_addr`=0x1234, `cpu_wdata`=0xA5A5A5A5 → next cycle `ram_we`=1, `addr`=0x1234, `ram_wdata`=0xA5A5A5A5; no `cpu_vld`.
- **Back-to-back reads:** 4 consecutive ui reads → 4 consecutive `ui_gnt` pulses and 4 consecutive `ui_vld` pulses, no bubbles.
